// File: rtl/proc_sequencer_if.sv
// Memory request bus between the sequencer (master) and the instruction/data memory (slave).
interface proc_sequencer_if #(
  parameter int WORD_W = 12,
  parameter int ADDR_W = 24
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, output mem_rdata, mem_ready);
endinterface

// File: rtl/proc_sequencer.sv
// Fetch/decode/execute sequencer: owns the IP, the memory handshake with wait states
// and single-level vectored interrupt entry/return.
module proc_sequencer #(
  parameter int                WORD_W     = 12,
  parameter int                ADDR_W     = 24,
  parameter int                NUM_IRQ    = 24,
  parameter logic [ADDR_W-1:0] RESET_IP   = '0,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 24'h000100,
  parameter int                VEC_STRIDE = 4
) (
  input  logic                clk,
  input  logic                rst,
  proc_sequencer_if.master    mem,
  output logic [WORD_W-1:0]   instr_o,
  output logic [WORD_W-1:0]   imm_o,
  input  logic                has_imm_i,
  input  logic                mem_rd_op_i,
  input  logic                mem_wr_op_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic                ip_load_i,
  input  logic [ADDR_W-1:0]   ip_load_val_i,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic                irq_en_i,
  input  logic                irq_ret_i,
  output logic [NUM_IRQ-1:0]  irq_ack_o,
  output logic                in_irq_o,
  output logic [ADDR_W-1:0]   ret_ip_o,
  output logic [ADDR_W-1:0]   ip_o,
  output logic [2:0]          stage_o,
  output logic                exec_strobe_o
);
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_IRQ} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] ret_ip_q, ret_ip_d;
  logic              in_irq_q, in_irq_d;

  logic [IDX_W-1:0]   irq_idx;
  logic [NUM_IRQ-1:0] irq_lowest;
  logic [ADDR_W-1:0]  vec_addr;
  logic               mem_op;
  logic               exec_done;
  logic               req_c, we_c;
  logic [ADDR_W-1:0]  addr_c;

  // Lowest-numbered pending line wins; scanning downward leaves the lowest index last.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_i[i]) irq_idx = IDX_W'(i);
    end
  end

  assign irq_lowest = irq_i & (~irq_i + NUM_IRQ'(1));
  assign vec_addr   = VEC_BASE + ADDR_W'(irq_idx) * ADDR_W'(VEC_STRIDE);
  assign mem_op     = mem_rd_op_i | mem_wr_op_i;
  assign exec_done  = (state_q == S_EXEC) && (!mem_op || mem.mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      ip_q     <= RESET_IP;
      instr_q  <= '0;
      imm_q    <= '0;
      ret_ip_q <= '0;
      in_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ip_q     <= ip_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      ret_ip_q <= ret_ip_d;
      in_irq_q <= in_irq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    ret_ip_d = ret_ip_q;
    in_irq_d = in_irq_q;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          instr_d = mem.mem_rdata;
          ip_d    = ip_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!has_imm_i) begin
          state_d = S_EXEC;
        end else if (mem.mem_ready) begin
          imm_d   = mem.mem_rdata;
          ip_d    = ip_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          // Return beats a jump; interrupt eligibility uses the pre-return in_irq.
          if (irq_ret_i && in_irq_q) begin
            ip_d     = ret_ip_q;
            in_irq_d = 1'b0;
          end else if (ip_load_i) begin
            ip_d = ip_load_val_i;
          end
          state_d = (irq_en_i && (|irq_i) && !in_irq_q) ? S_IRQ : S_FETCH;
        end
      end
      S_IRQ: begin
        ret_ip_d = ip_q;
        ip_d     = vec_addr;
        in_irq_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    req_c         = 1'b0;
    we_c          = 1'b0;
    addr_c        = ip_q;
    stage_o       = 3'b000;
    exec_strobe_o = 1'b0;
    irq_ack_o     = '0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          req_c   = 1'b1;
          stage_o = 3'b001;
        end
        S_DECODE: begin
          req_c   = has_imm_i;
          stage_o = 3'b010;
        end
        S_EXEC: begin
          req_c         = mem_op;
          we_c          = mem_wr_op_i;
          addr_c        = data_addr_i;
          stage_o       = 3'b100;
          exec_strobe_o = exec_done;
        end
        S_IRQ:   irq_ack_o = irq_lowest;
        default: stage_o = 3'b000;
      endcase
    end
  end

  assign mem.mem_req  = req_c;
  assign mem.mem_we   = we_c;
  assign mem.mem_addr = addr_c;

  assign instr_o  = instr_q;
  assign imm_o    = imm_q;
  assign ret_ip_o = ret_ip_q;
  assign in_irq_o = in_irq_q;
  assign ip_o     = ip_q;
endmodule
